// File: rtl/paddle_accel.sv
// Horizontal player paddle: per-frame velocity ramping, wall clamping and a
// registered paddle-coverage pixel for the VGA mux.
module paddle_accel #(
  parameter int unsigned SCREEN_WIDTH = 640,
  parameter int unsigned PADDLE_WIDTH = 50,
  parameter int unsigned X_MIN        = 2,
  parameter int unsigned Y_MIN        = 440,
  parameter int unsigned Y_MAX        = 459,
  parameter int unsigned MIN_SPEED    = 1,
  parameter int unsigned MAX_SPEED    = 8,
  parameter int unsigned ACCEL        = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       left,
  input  logic       right,
  input  logic [9:0] vgax,
  input  logic [8:0] vgay,
  output logic       pixel,
  output logic [9:0] paddle_x,
  output logic       moving
);

  localparam logic [10:0] X_MAX_C   = 11'(SCREEN_WIDTH - PADDLE_WIDTH);
  localparam logic [10:0] X_MIN_C   = 11'(X_MIN);
  localparam logic [10:0] X_RST_C   = 11'((SCREEN_WIDTH - PADDLE_WIDTH) / 2);
  localparam logic [10:0] MIN_SPD_C = 11'(MIN_SPEED);
  localparam logic [10:0] MAX_SPD_C = 11'(MAX_SPEED);
  localparam logic [10:0] ACCEL_C   = 11'(ACCEL);
  localparam logic [10:0] PW_M1_C   = 11'(PADDLE_WIDTH - 1);
  localparam logic [8:0]  Y_MIN_C   = 9'(Y_MIN);
  localparam logic [8:0]  Y_MAX_C   = 9'(Y_MAX);

  typedef enum logic [1:0] {IDLE, MOVE_L, MOVE_R} state_t;

  state_t      state_q, state_d, want_s;
  logic [10:0] x_q, x_d;
  logic [10:0] speed_q, speed_d;
  logic [10:0] ramp_s, spd_s;
  logic        pixel_q, pixel_d;
  logic        dir_l, dir_r;

  assign dir_r = right & ~left;
  assign dir_l = left & ~right;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= X_RST_C;
      speed_q <= '0;
      pixel_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      speed_q <= speed_d;
      pixel_q <= pixel_d;
    end
  end

  // Speed is chosen first (ramp or restart), then applied to x and possibly
  // overridden by the wall clamp in the same tick.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    speed_d = speed_q;
    want_s  = dir_r ? MOVE_R : MOVE_L;
    ramp_s  = (speed_q + ACCEL_C > MAX_SPD_C) ? MAX_SPD_C : speed_q + ACCEL_C;
    spd_s   = (want_s == state_q) ? ramp_s : MIN_SPD_C;
    if (frame_tick) begin
      if (!dir_l && !dir_r) begin
        state_d = IDLE;
        speed_d = '0;
      end else begin
        state_d = want_s;
        speed_d = spd_s;
        if (dir_r) begin
          if (x_q + spd_s >= X_MAX_C) begin
            x_d     = X_MAX_C;
            speed_d = MIN_SPD_C;
          end else begin
            x_d = x_q + spd_s;
          end
        end else begin
          if (x_q <= X_MIN_C + spd_s) begin
            x_d     = X_MIN_C;
            speed_d = MIN_SPD_C;
          end else begin
            x_d = x_q - spd_s;
          end
        end
      end
    end
  end

  always_comb begin
    moving  = (state_q == MOVE_L) || (state_q == MOVE_R);
    pixel_d = (vgay >= Y_MIN_C) && (vgay <= Y_MAX_C) &&
              ({1'b0, vgax} >= x_q) && ({1'b0, vgax} <= x_q + PW_M1_C);
  end

  assign pixel    = pixel_q;
  assign paddle_x = x_q[9:0];

endmodule

// File: tb/tb_paddle_accel.sv
// Directed bench for paddle_accel: reset, ramping, saturation, reversal,
// wall pinning, async reset mid-motion and pixel window edges.
module tb_paddle_accel;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       left = 1'b0;
  logic       right = 1'b0;
  logic [9:0] vgax = '0;
  logic [8:0] vgay = '0;
  logic       pixel;
  logic [9:0] paddle_x;
  logic       moving;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  paddle_accel #(
    .SCREEN_WIDTH(640),
    .PADDLE_WIDTH(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_tick(frame_tick),
    .left(left),
    .right(right),
    .vgax(vgax),
    .vgay(vgay),
    .pixel(pixel),
    .paddle_x(paddle_x),
    .moving(moving)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    left = 1'b0; right = 1'b0; frame_tick = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic tick(input logic l, input logic r);
    @(negedge clk);
    left = l; right = r; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    left = 1'b1; right = 1'b0; frame_tick = 1'b1;
    vgax = 10'd300; vgay = 9'd450;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (paddle_x !== 10'd295) begin
      errors++; $display("FAIL reset_x: got %0d want 295", paddle_x);
    end
    vectors++;
    if (pixel !== 1'b0) begin
      errors++; $display("FAIL reset_pixel: got %b want 0", pixel);
    end
    vectors++;
    if (moving !== 1'b0) begin
      errors++; $display("FAIL reset_moving: got %b want 0", moving);
    end
    rst = 1'b0; frame_tick = 1'b0; left = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ramp();
    logic [9:0] exp_x [5] = '{10'd296, 10'd298, 10'd301, 10'd305, 10'd310};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b1);
      vectors++;
      if (paddle_x !== exp_x[i]) begin
        errors++; $display("FAIL ramp_x[%0d]: got %0d want %0d", i, paddle_x, exp_x[i]);
      end
    end
    vectors++;
    if (moving !== 1'b1) begin
      errors++; $display("FAIL ramp_moving: got %b want 1", moving);
    end
  endtask

  task automatic test_saturate_right();
    logic       over;
    over = 1'b0;
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      tick(1'b0, 1'b1);
      if (paddle_x > 10'd590) over = 1'b1;
      if (i == 8) begin
        vectors++;
        if (paddle_x !== 10'd331) begin
          errors++; $display("FAIL sat_x8: got %0d want 331", paddle_x);
        end
      end
      if (i == 40) begin
        vectors++;
        if (paddle_x !== 10'd587) begin
          errors++; $display("FAIL sat_x40: got %0d want 587", paddle_x);
        end
      end
      if (i == 41) begin
        vectors++;
        if (paddle_x !== 10'd590) begin
          errors++; $display("FAIL sat_x41: got %0d want 590", paddle_x);
        end
      end
    end
    vectors++;
    if (paddle_x !== 10'd590) begin
      errors++; $display("FAIL sat_x100: got %0d want 590", paddle_x);
    end
    vectors++;
    if (over !== 1'b0) begin
      errors++; $display("FAIL sat_over: got %b want 0", over);
    end
  endtask

  task automatic test_reversal();
    do_reset();
    repeat (3) tick(1'b0, 1'b1);
    vectors++;
    if (paddle_x !== 10'd301) begin
      errors++; $display("FAIL rev_x_pre: got %0d want 301", paddle_x);
    end
    tick(1'b1, 1'b0);
    vectors++;
    if (paddle_x !== 10'd300 || moving !== 1'b1) begin
      errors++; $display("FAIL rev_left: got x=%0d mv=%b want x=300 mv=1", paddle_x, moving);
    end
    tick(1'b1, 1'b1);
    vectors++;
    if (paddle_x !== 10'd300 || moving !== 1'b0) begin
      errors++; $display("FAIL rev_both: got x=%0d mv=%b want x=300 mv=0", paddle_x, moving);
    end
    tick(1'b1, 1'b0);
    vectors++;
    if (paddle_x !== 10'd299) begin
      errors++; $display("FAIL rev_restart: got %0d want 299", paddle_x);
    end
  endtask

  task automatic test_pin_left();
    do_reset();
    @(negedge clk);
    left = 1'b1; frame_tick = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (paddle_x !== 10'd295 || moving !== 1'b0) begin
      errors++; $display("FAIL notick_x: got x=%0d mv=%b want x=295 mv=0", paddle_x, moving);
    end
    for (int i = 1; i <= 50; i++) begin
      tick(1'b1, 1'b0);
      if (i == 40) begin
        vectors++;
        if (paddle_x !== 10'd3) begin
          errors++; $display("FAIL pin_x40: got %0d want 3", paddle_x);
        end
      end
      if (i == 41) begin
        vectors++;
        if (paddle_x !== 10'd2) begin
          errors++; $display("FAIL pin_x41: got %0d want 2", paddle_x);
        end
      end
    end
    vectors++;
    if (paddle_x !== 10'd2 || moving !== 1'b1) begin
      errors++; $display("FAIL pin_hold: got x=%0d mv=%b want x=2 mv=1", paddle_x, moving);
    end
    @(negedge clk);
    left = 1'b1; frame_tick = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (paddle_x !== 10'd2) begin
      errors++; $display("FAIL pin_notick: got %0d want 2", paddle_x);
    end
    left = 1'b0;
  endtask

  task automatic test_reset_midmotion();
    do_reset();
    repeat (3) tick(1'b0, 1'b1);
    @(negedge clk);
    right = 1'b1;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (paddle_x !== 10'd295 || moving !== 1'b0) begin
      errors++; $display("FAIL midrst: got x=%0d mv=%b want x=295 mv=0", paddle_x, moving);
    end
    @(negedge clk);
    rst = 1'b0;
    tick(1'b0, 1'b1);
    vectors++;
    if (paddle_x !== 10'd296 || moving !== 1'b1) begin
      errors++; $display("FAIL midrst_first: got x=%0d mv=%b want x=296 mv=1", paddle_x, moving);
    end
    right = 1'b0;
  endtask

  task automatic test_pixel();
    logic [9:0] px [6] = '{10'd295, 10'd344, 10'd345, 10'd300, 10'd300, 10'd294};
    logic [8:0] py [6] = '{9'd440,  9'd440,  9'd440,  9'd459,  9'd460,  9'd450};
    logic       pe [6] = '{1'b1,    1'b1,    1'b0,    1'b1,    1'b0,    1'b0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vgax = px[i]; vgay = py[i];
      @(negedge clk);
      vectors++;
      if (pixel !== pe[i]) begin
        errors++; $display("FAIL pixel[%0d] (%0d,%0d): got %b want %b", i, px[i], py[i], pixel, pe[i]);
      end
    end
    // latency: new coordinates must not be visible before the next edge
    @(negedge clk);
    vgax = 10'd300; vgay = 9'd450;
    @(posedge clk);
    #1;
    vgax = 10'd0;
    @(negedge clk);
    vectors++;
    if (pixel !== 1'b1) begin
      errors++; $display("FAIL pixel_latency: got %b want 1", pixel);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_saturate_right();
    test_reversal();
    test_pin_left();
    test_reset_midmotion();
    test_pixel();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
